vnu_serial: RTL and testbench
=============================

VNU_SERIAL -- requirements
Module: vnu_serial

Interface
REQ-001 Parameters SHALL be: DV, default 3, variable-node degree (number of check-node messages); data_w, default 8, two's-complement message width; acc_w, default data_w+clog2(DV+1), accumulator width; idx_w, default clog2(DV), index width.
REQ-002 Ports SHALL be, in this order:
 clk  in  1  clock, rising edge;
 rst  in  1  reset, asynchronous, active-high;
 en  in  1  global enable; 0 freezes all registers;
 start  in  1  begin a new variable node, sampled in IDLE;
 llr_in  in  data_w  channel LLR, valid with start;
 r_in  in  data_w  check-to-variable message, one per beat;
 in_valid  in  1  r_in valid;
 in_ready  out  1  block accepts r_in;
 q_out  out  data_w  variable-to-check message;
 q_idx  out  idx_w  edge index of q_out;
 q_valid  out  1  q_out valid;
 q_ready  in  1  consumer accepts q_out;
 hard_dec  out  1  hard decision, 1 = negative posterior;
 dec_valid  out  1  one-cycle pulse, hard_dec updated;
 busy  out  1  state != IDLE.

Function
REQ-003 The FSM SHALL have three states: IDLE, ACCUM and EMIT; all transitions SHALL occur only when en=1.
REQ-004 In IDLE with start=1, the block SHALL capture sign-extended llr_in into total, clear cnt, and enter ACCUM; start SHALL be ignored in all other states.
REQ-005 In ACCUM, in_ready SHALL be 1; on in_valid&in_ready, the block SHALL store r_in in buf[cnt], add sign-extended r_in to total, and increment cnt.
REQ-006 An accepted beat with cnt==DV-1 SHALL clear cnt and move the FSM to EMIT; in the same edge, hard_dec SHALL be set to the sign of the final total and dec_valid SHALL pulse high for exactly one cycle.
REQ-007 In EMIT, q_valid SHALL be 1, q_idx SHALL equal cnt, and q_out SHALL equal sat(total - buf[cnt]), combinational from registers.
REQ-008 On q_valid&q_ready, cnt SHALL increment; the handshake at cnt==DV-1 SHALL return the FSM to IDLE in that edge.
REQ-009 While q_ready=0, q_out, q_idx and q_valid SHALL hold stable.
REQ-010 sat() SHALL clamp to the symmetric range [-(2^(data_w-1)-1), +(2^(data_w-1)-1)], so -2^(data_w-1) is never emitted.
REQ-011 All sums SHALL be computed at acc_w bits signed with no intermediate overflow; subtraction SHALL also be done at acc_w bits.
REQ-012 When en=0: in_ready=0, q_valid=0, dec_valid=0, and no register changes.
REQ-013 Outside ACCUM, in_ready SHALL be 0; outside EMIT, q_valid SHALL be 0; q_out SHALL be 0 when q_valid=0.
REQ-014 Latency from the last accepted r_in beat to the first q_valid SHALL be 1 cycle; throughput SHALL be one beat per cycle in both phases.

Reset
REQ-015 On rst=1, asynchronously: state=IDLE, cnt=0, total=0, buf=0, hard_dec=0, dec_valid=0, and outputs in_ready, q_valid, q_out, q_idx and busy all 0.
REQ-016 rst asserted mid-ACCUM or mid-EMIT SHALL discard the node; after deassertion, the block SHALL accept only a fresh start.

Structure
REQ-017 A shared package SHALL hold data_w, DV, the clog2 function and the FSM state encoding, common with the check-node side.
REQ-018 A single sub-module, sat (acc_w in, data_w out, combinational), SHALL implement REQ-010.

Verification
(All scenarios use DV=3 and data_w=8.)
REQ-019 Nominal: llr=10, r=5,-3,7 -> q=14,22,12 on q_idx 0,1,2, hard_dec=0, and dec_valid pulses once.
REQ-020 Positive saturation: llr=127, r=127,127,127 -> total=508, q=127 on all three edges, hard_dec=0.
REQ-021 Negative saturation: llr=-20, r=-100,-100,-100 -> q=-127 x3 (never -128), hard_dec=1.
REQ-022 Backpressure: q_ready low for 3 cycles on edge 1 -> q_out/q_idx held at 22/1, and completion is delayed by exactly 3 cycles.
REQ-023 Gaps and en: in_valid gaps plus en=0 for 2 cycles mid-ACCUM -> no beat lost, results as in REQ-019, and start pulses during ACCUM are ignored.
REQ-024 Reset mid-operation: rst pulsed after 2 accepted beats -> busy=0 and all outputs 0; a following llr=0, r=1,1,1 node -> q=2,2,2.

Source files
------------

// File: rtl/vnu_serial_pkg.sv
// Shared LDPC decoder definitions: default message sizing, the ceil-log2
// helper and the node FSM state encoding used by the variable and check nodes.
package vnu_serial_pkg;

    localparam int DEF_DV     = 3;  // variable-node degree
    localparam int DEF_DATA_W = 8;  // two's-complement message width

    // Ceil-log2 for sizing counters and accumulators at elaboration time.
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        while ((1 << bits) < value) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EMIT  = 2'd2
    } node_state_t;

endpackage

// File: rtl/vnu_serial_sat.sv
// Symmetric saturation of a wide accumulator value down to message width.
// The most negative code is never produced, so every output has a negation.
module vnu_serial_sat #(
    parameter int acc_w  = 10,
    parameter int data_w = 8
) (
    input  logic signed [acc_w-1:0]  i_acc,
    output logic signed [data_w-1:0] o_sat
);

    localparam logic signed [acc_w-1:0] SAT_MAX = acc_w'((2 ** (data_w - 1)) - 1);
    localparam logic signed [acc_w-1:0] SAT_MIN = -SAT_MAX;

    // Clamp to [-(2^(data_w-1)-1), +(2^(data_w-1)-1)].
    always_comb begin
        if (i_acc > SAT_MAX) begin
            o_sat = SAT_MAX[data_w-1:0];
        end else if (i_acc < SAT_MIN) begin
            o_sat = SAT_MIN[data_w-1:0];
        end else begin
            o_sat = i_acc[data_w-1:0];
        end
    end

endmodule

// File: rtl/vnu_serial.sv
// Serial LDPC variable-node update. A node is opened with its channel LLR,
// absorbs DV check-to-variable messages one per beat, then emits DV
// extrinsic messages q[k] = sat(total - r[k]) one per beat.
module vnu_serial
    import vnu_serial_pkg::*;
#(
    parameter int DV     = DEF_DV,
    parameter int data_w = DEF_DATA_W,
    parameter int acc_w  = data_w + clog2(DV + 1),
    parameter int idx_w  = clog2(DV)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    input  logic [data_w-1:0] llr_in,
    input  logic [data_w-1:0] r_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [data_w-1:0] q_out,
    output logic [idx_w-1:0]  q_idx,
    output logic              q_valid,
    input  logic              q_ready,
    output logic              hard_dec,
    output logic              dec_valid,
    output logic              busy
);

    localparam int                EXT_W    = acc_w - data_w;
    localparam logic [idx_w-1:0]  LAST_IDX = idx_w'(DV - 1);

    node_state_t                     r_state;
    node_state_t                     w_state_next;
    logic        [idx_w-1:0]         r_cnt;
    logic signed [acc_w-1:0]         r_total;
    logic        [data_w-1:0]        r_buf [DV];
    logic                            r_hard_dec;
    logic                            r_dec_valid;

    logic                            w_capture;
    logic                            w_accept;
    logic                            w_emit;
    logic signed [acc_w-1:0]         w_llr_ext;
    logic signed [acc_w-1:0]         w_r_ext;
    logic signed [acc_w-1:0]         w_buf_ext;
    logic signed [acc_w-1:0]         w_total_next;
    logic signed [acc_w-1:0]         w_extrinsic;
    logic signed [data_w-1:0]        w_sat;

    // Sign-extend operands so every sum and difference is exact at acc_w bits.
    assign w_llr_ext    = {{EXT_W{llr_in[data_w-1]}}, llr_in};
    assign w_r_ext      = {{EXT_W{r_in[data_w-1]}}, r_in};
    assign w_buf_ext    = {{EXT_W{r_buf[r_cnt][data_w-1]}}, r_buf[r_cnt]};
    assign w_total_next = r_total + w_r_ext;
    assign w_extrinsic  = r_total - w_buf_ext;

    vnu_serial_sat #(
        .acc_w  (acc_w),
        .data_w (data_w)
    ) u_sat (
        .i_acc (w_extrinsic),
        .o_sat (w_sat)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: sequential state always uses <=, so every register samples
            // pre-edge values regardless of statement order.
            r_state <= w_state_next;
        end
    end

    // Next-state decode and handshake strobes; nothing moves while en is low.
    always_comb begin
        // NOTE: every output of this block gets a default first, otherwise a
        // path that skips an assignment would infer a latch.
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_accept     = 1'b0;
        w_emit       = 1'b0;
        in_ready     = 1'b0;
        q_valid      = 1'b0;
        if (en) begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_capture    = 1'b1;
                        w_state_next = ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        w_accept = 1'b1;
                        if (r_cnt == LAST_IDX) begin
                            w_state_next = ST_EMIT;
                        end
                    end
                end
                ST_EMIT: begin
                    q_valid = 1'b1;
                    if (q_ready) begin
                        w_emit = 1'b1;
                        if (r_cnt == LAST_IDX) begin
                            w_state_next = ST_IDLE;
                        end
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Datapath: LLR capture, message buffering/accumulation, edge counter, decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_total     <= '0;
            r_hard_dec  <= 1'b0;
            r_dec_valid <= 1'b0;
            // NOTE: the message buffer is small and is cleared on reset so no
            // stale message from an aborted node can ever reach q_out.
            for (int i = 0; i < DV; i++) begin
                r_buf[i] <= '0;
            end
        end else if (en) begin
            r_dec_valid <= 1'b0;
            if (w_capture) begin
                r_total <= w_llr_ext;
                r_cnt   <= '0;
            end
            if (w_accept) begin
                r_buf[r_cnt] <= r_in;
                r_total      <= w_total_next;
                if (r_cnt == LAST_IDX) begin
                    r_cnt       <= '0;
                    r_hard_dec  <= w_total_next[acc_w-1];
                    r_dec_valid <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (w_emit) begin
                r_cnt <= (r_cnt == LAST_IDX) ? '0 : r_cnt + 1'b1;
            end
        end
    end

    assign q_out     = q_valid ? w_sat : '0;
    assign q_idx     = q_valid ? r_cnt : '0;
    assign hard_dec  = r_hard_dec;
    assign dec_valid = en & r_dec_valid;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_vnu_serial.sv
// Directed bench for vnu_serial (DV=3, data_w=8): nominal node, both
// saturation corners, output backpressure, input gaps with enable drops and
// stray starts, and reset in the middle of a node.
module tb_vnu_serial;

    logic       clk;
    logic       rst;
    logic       en;
    logic       start;
    logic [7:0] llr_in;
    logic [7:0] r_in;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] q_out;
    logic [1:0] q_idx;
    logic       q_valid;
    logic       q_ready;
    logic       hard_dec;
    logic       dec_valid;
    logic       busy;

    int n_vec  = 0;
    int n_miss = 0;

    vnu_serial #(
        .DV     (3),
        .data_w (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .start     (start),
        .llr_in    (llr_in),
        .r_in      (r_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q_out     (q_out),
        .q_idx     (q_idx),
        .q_valid   (q_valid),
        .q_ready   (q_ready),
        .hard_dec  (hard_dec),
        .dec_valid (dec_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; return 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_node(input int llr);
        start  = 1'b1;
        llr_in = 8'(llr);
        #1;
        check("idle_before_start", int'(busy), 0);
        tick();
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
    endtask

    task automatic send_beat(input int r);
        in_valid = 1'b1;
        r_in     = 8'(r);
        #1;
        check("in_ready_accum", int'(in_ready), 1);
        check("q_valid_accum", int'(q_valid), 0);
        tick();
        in_valid = 1'b0;
    endtask

    // Drain the three extrinsic messages, optionally stalling before edge stall_idx.
    task automatic recv(input int e0, input int e1, input int e2, input int hd,
                        input int stall_idx, input int stall_n);
        int exp_q[3];
        exp_q[0] = e0;
        exp_q[1] = e1;
        exp_q[2] = e2;
        for (int i = 0; i < 3; i++) begin
            if (i == stall_idx) begin
                for (int s = 0; s < stall_n; s++) begin
                    q_ready = 1'b0;
                    #1;
                    check("stall_q_valid", int'(q_valid), 1);
                    check("stall_q_idx", int'(q_idx), i);
                    check("stall_q_out", int'($signed(q_out)), exp_q[i]);
                    check("stall_busy", int'(busy), 1);
                    tick();
                end
            end
            q_ready = 1'b1;
            #1;
            check("q_valid", int'(q_valid), 1);
            check("q_idx", int'(q_idx), i);
            check("q_out", int'($signed(q_out)), exp_q[i]);
            check("dec_valid_pulse", int'(dec_valid), (i == 0 && stall_idx != 0) ? 1 : 0);
            check("hard_dec", int'(hard_dec), hd);
            check("in_ready_emit", int'(in_ready), 0);
            tick();
        end
        q_ready = 1'b0;
        #1;
        check("done_busy", int'(busy), 0);
        check("done_q_valid", int'(q_valid), 0);
        check("done_q_out", int'(q_out), 0);
        check("done_dec_valid", int'(dec_valid), 0);
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b1;
        start    = 1'b0;
        llr_in   = '0;
        r_in     = '0;
        in_valid = 1'b0;
        q_ready  = 1'b0;
        #3;
        check("rst_busy", int'(busy), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_q_valid", int'(q_valid), 0);
        check("rst_q_out", int'(q_out), 0);
        check("rst_q_idx", int'(q_idx), 0);
        check("rst_hard_dec", int'(hard_dec), 0);
        check("rst_dec_valid", int'(dec_valid), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Nominal: total = 10+5-3+7 = 19 -> q = 14, 22, 12.
        start_node(10);
        send_beat(5);
        send_beat(-3);
        send_beat(7);
        recv(14, 22, 12, 0, -1, 0);

        // Positive saturation: total = 508, every q = 381 clamps to 127.
        start_node(127);
        send_beat(127);
        send_beat(127);
        send_beat(127);
        recv(127, 127, 127, 0, -1, 0);

        // Negative saturation: total = -320, every q = -220 clamps to -127.
        start_node(-20);
        send_beat(-100);
        send_beat(-100);
        send_beat(-100);
        recv(-127, -127, -127, 1, -1, 0);

        // Backpressure: three stall cycles on edge 1 hold 22 / idx 1.
        start_node(10);
        send_beat(5);
        send_beat(-3);
        send_beat(7);
        recv(14, 22, 12, 0, 1, 3);

        // Gaps, en=0 for two cycles and stray starts inside ACCUM.
        start_node(10);
        send_beat(5);
        start  = 1'b1;
        llr_in = 8'(50);
        #1;
        check("gap_in_ready", int'(in_ready), 1);
        tick();
        start    = 1'b0;
        en       = 1'b0;
        in_valid = 1'b1;
        r_in     = 8'(99);
        for (int k = 0; k < 2; k++) begin
            #1;
            check("en0_in_ready", int'(in_ready), 0);
            check("en0_q_valid", int'(q_valid), 0);
            check("en0_busy", int'(busy), 1);
            tick();
        end
        en       = 1'b1;
        in_valid = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        send_beat(-3);
        tick();
        send_beat(7);
        recv(14, 22, 12, 0, -1, 0);

        // Reset after two accepted beats discards the node.
        start_node(-20);
        send_beat(-100);
        send_beat(-100);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_in_ready", int'(in_ready), 0);
        check("mid_rst_q_valid", int'(q_valid), 0);
        check("mid_rst_q_out", int'(q_out), 0);
        check("mid_rst_q_idx", int'(q_idx), 0);
        check("mid_rst_hard_dec", int'(hard_dec), 0);
        check("mid_rst_dec_valid", int'(dec_valid), 0);
        tick();
        rst      = 1'b0;
        in_valid = 1'b1;
        r_in     = 8'(-100);
        #1;
        check("post_rst_no_beat", int'(in_ready), 0);
        tick();
        in_valid = 1'b0;
        start_node(0);
        send_beat(1);
        send_beat(1);
        send_beat(1);
        recv(2, 2, 2, 0, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
